// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units (adder now, a
// subtractor later). Holds the control FSM state type and the default
// operand width.
package serial_arith_pkg;

  // Control FSM states shared by every serial arithmetic unit.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default operand and result width in bits.
  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_fa.sv
// full_adder_df: 1-bit dataflow full adder cell.
// Ports:
//   a, b, cin : operand bits and carry-in
//   s         : sum bit
//   cout      : carry-out (majority of the three inputs)
module full_adder_df (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder. Accepts two WIDTH-bit operands and a
// carry-in through a valid/ready handshake, adds them LSB-first over WIDTH
// cycles using one full-adder cell and a carry flop, then pulses done for one
// cycle with the registered sum and carry-out.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   start_valid : operand request; start_ready is high only in IDLE
//   a, b, cin   : operands and carry-in, sampled at accept
//   sum, cout   : registered result, held until the next completed operation
//   done        : one-cycle pulse after the result updates
//   busy        : high while an operation is in flight (RUN and DONE)
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;

  full_adder_df u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign last_bit = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    start_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          next_state = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // The count holds at its terminal value on the last bit rather than
  // wrapping; it is reloaded on the next accept anyway. The final sum takes
  // the freshly computed MSB directly so it lands on the same edge as cout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            sum_sh <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_c;
          if (last_bit) begin
            sum  <= {fa_s, sum_sh[WIDTH-1:1]};
            cout <= fa_c;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder with an arithmetic reference model
// ({cout,sum} = a + b + cin) and an exhaustive check of full_adder_df.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         done;
  logic         busy;

  logic fa_a, fa_b, fa_cin, fa_s, fa_cout;

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sum         (sum),
    .cout        (cout),
    .done        (done),
    .busy        (busy)
  );

  full_adder_df fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (fa_cin),
    .s    (fa_s),
    .cout (fa_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer addition.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Drives one operation from IDLE and records what the DUT did over the
  // following W+4 cycles. No comparisons here; callers judge the results.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        input bit scramble,
                        output logic [W-1:0] s_obs, output logic c_obs,
                        output int done_cnt, output int latency, output bit sum_held,
                        output logic ready_at_done, output logic ready_after,
                        output bit overlap);
    logic [W-1:0] prev;
    @(negedge clk);
    start_valid = 1'b1;
    a = xa;
    b = xb;
    cin = xc;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    if (scramble) begin
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
    end
    prev = sum;
    s_obs = 'x;
    c_obs = 1'bx;
    done_cnt = 0;
    latency = -1;
    sum_held = 1'b1;
    ready_at_done = 1'bx;
    ready_after = 1'bx;
    overlap = 1'b0;
    for (int cyc = 1; cyc <= W + 4; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (scramble) begin
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (latency < 0) begin
          latency = cyc;
          s_obs = sum;
          c_obs = cout;
        end
        if (start_ready === 1'b1) overlap = 1'b1;
      end
      if (cyc < W && sum !== prev) sum_held = 1'b0;
      if (cyc == W) ready_at_done = start_ready;
      if (cyc == W + 1) ready_after = start_ready;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sum !== '0 || cout !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_state: sum=%h cout=%b done=%b busy=%b ready=%b required 00 0 0 0 1",
               sum, cout, done, busy, start_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_release: got %b required 1", start_ready);
    end
  endtask

  // Directed vectors plus timing details of each operation.
  task automatic test_directed;
    logic [W-1:0] va [4] = '{8'h00, 8'hFF, 8'h5A, 8'hFF};
    logic [W-1:0] vb [4] = '{8'h00, 8'h01, 8'h3C, 8'hFF};
    logic         vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] s_obs;
    logic c_obs, rdy_d, rdy_a;
    int dcnt, lat;
    bit held, ovl;
    logic [W:0] exp;
    for (int i = 0; i < 4; i++) begin
      exp = ref_add(va[i], vb[i], vc[i]);
      run_op(va[i], vb[i], vc[i], 1'b0, s_obs, c_obs, dcnt, lat, held, rdy_d, rdy_a, ovl);
      checks++;
      if ({c_obs, s_obs} !== exp) begin
        errors++;
        $display("[TB] FAIL directed_%0d_result: got cout=%b sum=%h required cout=%b sum=%h",
                 i, c_obs, s_obs, exp[W], exp[W-1:0]);
      end
      checks++;
      if (dcnt != 1 || lat != W) begin
        errors++;
        $display("[TB] FAIL directed_%0d_done: got %0d pulses at cycle %0d required 1 at %0d",
                 i, dcnt, lat, W);
      end
      checks++;
      if (rdy_d !== 1'b0 || rdy_a !== 1'b1 || ovl) begin
        errors++;
        $display("[TB] FAIL directed_%0d_ready: at_done=%b after=%b overlap=%0d required 0 1 0",
                 i, rdy_d, rdy_a, ovl);
      end
      checks++;
      if (!held) begin
        errors++;
        $display("[TB] FAIL directed_%0d_sum_hold: sum changed before final RUN edge", i);
      end
    end
  endtask

  // start_valid held high during RUN with new operands: the first result is
  // unaffected and the second operation starts only after returning to IDLE.
  task automatic test_back_to_back;
    int dcnt = 0;
    int first_cyc = -1;
    int second_cyc = -1;
    logic [W-1:0] s1, s2;
    logic c1, c2;
    @(negedge clk);
    start_valid = 1'b1;
    a = 8'h12;
    b = 8'h34;
    cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 8'hAA;
    b = 8'h55;
    for (int cyc = 1; cyc <= 2 * W + 5; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == W + 2) start_valid = 1'b0;
      if (done === 1'b1) begin
        dcnt++;
        if (first_cyc < 0) begin
          first_cyc = cyc;
          s1 = sum;
          c1 = cout;
        end else if (second_cyc < 0) begin
          second_cyc = cyc;
          s2 = sum;
          c2 = cout;
        end
      end
    end
    checks++;
    if (first_cyc != W || s1 !== 8'h46 || c1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_first: cyc=%0d sum=%h cout=%b required cyc=%0d sum=46 cout=0",
               first_cyc, s1, c1, W);
    end
    checks++;
    if (second_cyc != 2 * W + 2 || s2 !== 8'hFF || c2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_second: cyc=%0d sum=%h cout=%b required cyc=%0d sum=ff cout=0",
               second_cyc, s2, c2, 2 * W + 2);
    end
    checks++;
    if (dcnt != 2) begin
      errors++;
      $display("[TB] FAIL b2b_done_count: got %0d required 2", dcnt);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [W-1:0] s_obs;
    logic c_obs, rdy_d, rdy_a;
    int dcnt, lat;
    bit held, ovl;
    int stray = 0;
    @(negedge clk);
    start_valid = 1'b1;
    a = 8'hF0;
    b = 8'h0F;
    cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (sum !== '0 || cout !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrun_reset: sum=%h cout=%b done=%b busy=%b ready=%b required 00 0 0 0 1",
               sum, cout, done, busy, start_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < W + 2; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("[TB] FAIL midrun_no_done: got %0d pulses required 0", stray);
    end
    run_op(8'h01, 8'h01, 1'b0, 1'b0, s_obs, c_obs, dcnt, lat, held, rdy_d, rdy_a, ovl);
    checks++;
    if (s_obs !== 8'h02 || c_obs !== 1'b0 || dcnt != 1) begin
      errors++;
      $display("[TB] FAIL after_reset_op: sum=%h cout=%b dones=%0d required 02 0 1",
               s_obs, c_obs, dcnt);
    end
  endtask

  // Random operands; every other operation also scrambles the inputs after
  // accept, which must not affect the result.
  task automatic test_random;
    logic [W-1:0] ra, rb, s_obs;
    logic rc, c_obs, rdy_d, rdy_a;
    int dcnt, lat;
    bit held, ovl;
    logic [W:0] exp;
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      exp = ref_add(ra, rb, rc);
      run_op(ra, rb, rc, (i % 2) == 1, s_obs, c_obs, dcnt, lat, held, rdy_d, rdy_a, ovl);
      checks++;
      if ({c_obs, s_obs} !== exp || dcnt != 1 || lat != W || !held) begin
        errors++;
        $display("[TB] FAIL random_%0d: %h+%h+%b got cout=%b sum=%h dones=%0d lat=%0d held=%0d required cout=%b sum=%h 1 %0d 1",
                 i, ra, rb, rc, c_obs, s_obs, dcnt, lat, held, exp[W], exp[W-1:0], W);
      end
    end
  endtask

  task automatic test_full_adder;
    logic [2:0] v;
    int total;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      fa_a = v[2];
      fa_b = v[1];
      fa_cin = v[0];
      #1;
      total = int'(v[2]) + int'(v[1]) + int'(v[0]);
      checks++;
      if (fa_s !== 1'(total % 2) || fa_cout !== 1'(total / 2)) begin
        errors++;
        $display("[TB] FAIL full_adder_%0d: got s=%b cout=%b required s=%0d cout=%0d",
                 i, fa_s, fa_cout, total % 2, total / 2);
      end
    end
  endtask

  initial begin
    fa_a = 1'b0;
    fa_b = 1'b0;
    fa_cin = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    test_full_adder();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
